multicycle_seq: RTL and testbench

- Multicycle sequencer for the control/regFile/alu_stage datapath.
- Steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB.
- Handshakes with instruction and data memory over req/ack.
- Generates the enables the datapath needs: IR load, regFile write, ALU enable, PC update and branch select. Also provides halt, memory-timeout error and a retired-instruction counter.

---
 rtl/multicycle_seq.sv | 142 ++++++++++++++
 tb/tb_multicycle_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_seq.sv
// Multicycle instruction sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB
// and generates the datapath enables, memory handshakes, timeout error and retire count.
module multicycle_seq #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic [1:0]       op_class,
  input  logic             zero,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  output logic             alu_en,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             wrt_en,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             err,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_HALTED = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OP_ALU    = 2'b00,
    OP_LOAD   = 2'b01,
    OP_STORE  = 2'b10,
    OP_BRANCH = 2'b11
  } op_t;

  typedef struct packed {
    logic imem_req;
    logic ir_we;
    logic alu_en;
    logic dmem_req;
    logic dmem_we;
    logic wrt_en;
    logic pc_we;
    logic pc_sel;
  } strb_t;

  state_t     state, state_nxt;
  op_t        op_q;
  logic [7:0] wait_cnt;
  logic       wait_exp;
  strb_t      strb;

  // Last permitted wait cycle: no ack here means the counter would reach MEM_TIMEOUT.
  always_comb wait_exp = (wait_cnt == 8'(MEM_TIMEOUT - 1));

  always_comb begin
    strb      = '0;
    state_nxt = state;
    case (state)
      S_HALTED: if (!halt) state_nxt = S_FETCH;
      S_FETCH: begin
        strb.imem_req = 1'b1;
        if (imem_ack) begin
          strb.ir_we = 1'b1;
          state_nxt  = S_DECODE;
        end else if (wait_exp) begin
          state_nxt = S_ERROR;
        end
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        strb.alu_en = 1'b1;
        case (op_q)
          OP_ALU:            state_nxt = S_WB;
          OP_LOAD, OP_STORE: state_nxt = S_MEM;
          default: begin
            strb.pc_we  = 1'b1;
            strb.pc_sel = zero;
          end
        endcase
      end
      S_MEM: begin
        strb.dmem_req = 1'b1;
        strb.dmem_we  = (op_q == OP_STORE);
        if (dmem_ack) begin
          if (op_q == OP_STORE) strb.pc_we = 1'b1;
          else                  state_nxt  = S_WB;
        end else if (wait_exp) begin
          state_nxt = S_ERROR;
        end
      end
      S_WB: begin
        strb.wrt_en = 1'b1;
        strb.pc_we  = 1'b1;
      end
      S_ERROR: state_nxt = S_ERROR;
      default: state_nxt = S_ERROR;
    endcase
    // Every pc_we marks the instruction boundary, where halt is honoured.
    if (strb.pc_we) state_nxt = halt ? S_HALTED : S_FETCH;
    // Strobes are killed combinationally so a reset mid-request issues nothing.
    if (reset) strb = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_HALTED;
      op_q     <= OP_ALU;
      wait_cnt <= '0;
      err      <= 1'b0;
      retired  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) op_q <= op_t'(op_class);
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (state == S_FETCH || state == S_MEM)
        wait_cnt <= wait_cnt + 8'd1;
      if (state_nxt == S_ERROR) err <= 1'b1;
      retired <= retired + CNT_W'(strb.pc_we);
    end
  end

  assign imem_req = strb.imem_req;
  assign ir_we    = strb.ir_we;
  assign alu_en   = strb.alu_en;
  assign dmem_req = strb.dmem_req;
  assign dmem_we  = strb.dmem_we;
  assign wrt_en   = strb.wrt_en;
  assign pc_we    = strb.pc_we;
  assign pc_sel   = strb.pc_sel;
  assign state_o  = state;

endmodule

// File: tb/tb_multicycle_seq.sv
// Scoreboard bench for multicycle_seq: each issued instruction pushes its expected
// completion (pc_sel, wrt_en, latency); a negedge monitor pops on every pc_we.
module tb_multicycle_seq;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, halt, zero, imem_ack, dmem_ack;
  logic [1:0]  op_class;
  logic        imem_req, ir_we, alu_en, dmem_req, dmem_we, wrt_en, pc_we, pc_sel, err;
  logic [2:0]  state_o;
  logic [31:0] retired;

  multicycle_seq #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .halt(halt), .op_class(op_class), .zero(zero),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we), .alu_en(alu_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .wrt_en(wrt_en),
    .pc_we(pc_we), .pc_sel(pc_sel), .err(err), .state_o(state_o), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pc_sel;
    logic wrt;
    int   lat;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0, n_err = 0;
  int          cyc = 0, start = 0;
  logic [2:0]  prev_st = 3'd0;
  logic [31:0] exp_ret = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    cyc++;
    if (reset) begin
      exp_ret = 32'd0;
      start   = cyc;
    end else begin
      if (state_o == 3'd1 && prev_st != 3'd1) start = cyc;
      if (wrt_en && !pc_we) chk("wrt_en_stray", 32'(wrt_en), 32'd0);
      if (pc_we) begin
        chk("pc_we_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pc_sel", 32'(pc_sel), 32'(e.pc_sel));
          chk("wrt_en", 32'(wrt_en), 32'(e.wrt));
          chk("latency", 32'(cyc - start + 1), 32'(e.lat));
          chk("retired", retired, exp_ret);
          exp_ret++;
        end
      end
    end
    prev_st = state_o;
  end

  // Acts as both memories: ack after iw/dw wait cycles; hm/hw raise halt in MEM/WB.
  task automatic run_instr(input logic [1:0] op, input logic z, input int iw, input int dw,
                           input bit hm, input bit hw);
    exp_t e;
    int   fc, dc;
    bit   done;
    e.pc_sel = (op == 2'b11) ? z : 1'b0;
    e.wrt    = (op == 2'b00 || op == 2'b01);
    e.lat    = (op == 2'b00) ? 4 : (op == 2'b11) ? 3 : (op == 2'b01) ? 5 + dw : 4 + dw;
    e.lat   += iw;
    sb.push_back(e);
    op_class = op;
    zero     = z;
    fc = 0; dc = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (state_o == 3'd1) begin imem_ack = (fc == iw); fc++; end
      if (state_o == 3'd4) begin dmem_ack = (dc == dw); dc++; if (hm) halt = 1'b1; end
      if (state_o == 3'd5 && hw) halt = 1'b1;
      #1;
      if (state_o == 3'd1) chk("ir_we", 32'(ir_we), 32'(imem_ack));
      if (state_o == 3'd4) begin
        chk("dmem_req", 32'(dmem_req), 32'd1);
        chk("dmem_we", 32'(dmem_we), 32'(op == 2'b10));
      end
      if (pc_we) done = 1;
      step;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    chk("instr_done", 32'(done), 32'd1);
    if (halt) begin
      #1;
      chk("halted", 32'(state_o), 32'd0);
      halt = 1'b0;
    end
  endtask

  initial begin
    int fcyc;
    reset = 1'b1; halt = 1'b1; zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; op_class = 2'b00;
    repeat (3) step;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_strobes", 32'({imem_req, ir_we, alu_en, dmem_req, dmem_we, wrt_en, pc_we}), 32'd0);
    reset = 1'b0;
    step;
    chk("idle_halted", 32'(state_o), 32'd0);
    halt = 1'b0;

    run_instr(2'b00, 1'b0, 0, 0, 0, 0);   // ALU
    run_instr(2'b11, 1'b1, 0, 0, 0, 0);   // BRANCH taken
    run_instr(2'b11, 1'b0, 0, 0, 0, 0);   // BRANCH not taken
    run_instr(2'b01, 1'b0, 1, 3, 0, 0);   // LOAD, dmem ack on the timeout cycle
    run_instr(2'b10, 1'b0, 0, 0, 0, 0);   // STORE immediate ack
    run_instr(2'b00, 1'b0, 3, 0, 0, 1);   // imem ack on timeout cycle, halt in WB
    run_instr(2'b01, 1'b0, 0, 2, 1, 0);   // halt raised mid-MEM
    run_instr(2'b10, 1'b0, 2, 1, 0, 0);
    for (int i = 0; i < 10; i++)
      run_instr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                $urandom_range(0, 3), 0, ($urandom_range(0, 3) == 0));
    chk("retired_total", retired, exp_ret);

    // Reset while waiting in MEM.
    op_class = 2'b01;
    for (int c = 0; c < 16 && state_o != 3'd4; c++) begin
      imem_ack = (state_o == 3'd1);
      step;
    end
    imem_ack = 1'b0;
    chk("in_mem", 32'(state_o), 32'd4);
    reset = 1'b1; halt = 1'b1;
    #1;
    chk("rst_mem_strobes", 32'({pc_we, wrt_en, dmem_req}), 32'd0);
    step;
    chk("rst_mem_state", 32'(state_o), 32'd0);
    chk("rst_mem_retired", retired, 32'd0);
    reset = 1'b0;
    step;
    chk("rst_mem_hold", 32'(state_o), 32'd0);

    // Fetch timeout into ERROR.
    halt = 1'b0;
    fcyc = 0;
    for (int c = 0; c < 20 && state_o != 3'd6; c++) begin
      if (state_o == 3'd1) fcyc++;
      step;
    end
    chk("to_fetch_cycles", 32'(fcyc), 32'(TO));
    chk("to_err", 32'(err), 32'd1);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (3) step;
    chk("err_state", 32'(state_o), 32'd6);
    chk("err_sticky", 32'(err), 32'd1);
    chk("err_strobes", 32'({imem_req, ir_we, alu_en, dmem_req, wrt_en, pc_we}), 32'd0);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    reset = 1'b1; halt = 1'b1;
    step;
    reset = 1'b0;
    step;
    chk("err_cleared", 32'(err), 32'd0);
    chk("err_rst_state", 32'(state_o), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
